// File: rtl/e_xlu.sv
// e_xlu: E-stage multiply/divide unit owning HI/LO.
// Fixed-latency mult/div with start/busy for D-stage stall control.
module e_xlu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  xlu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] xlu_out
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_we;
    logic        commit;

    logic        op_md, op_div, op_sgn;
    logic        op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic        neg_a, neg_b, b_zero;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, div_b;
    logic [31:0] q_mag, r_mag, quot, rem;

    assign op_md   = (xlu_op[3:2] == 2'b00);
    assign op_div  = op_md & xlu_op[1];
    assign op_sgn  = ~xlu_op[0];
    assign op_mthi = (xlu_op == 4'b0100);
    assign op_mtlo = (xlu_op == 4'b0101);
    assign op_mfhi = (xlu_op == 4'b0110);
    assign op_mflo = (xlu_op == 4'b0111);

    assign busy  = (state == RUN);
    assign start = op_md & ~busy & ~req & reset;

    // Sign-extend for mult, zero-extend for multu; low 64 bits are exact.
    assign ext_a = {{32{op_sgn & a[31]}}, a};
    assign ext_b = {{32{op_sgn & b[31]}}, b};
    assign prod  = ext_a * ext_b;

    // Divide on magnitudes, then fix signs; avoids the
    // 0x80000000 / -1 overflow corner entirely.
    assign neg_a  = op_sgn & a[31];
    assign neg_b  = op_sgn & b[31];
    assign b_zero = (b == 32'd0);
    assign mag_a  = neg_a ? -a : a;
    assign mag_b  = neg_b ? -b : b;
    assign div_b  = b_zero ? 32'd1 : mag_b;
    assign q_mag  = mag_a / div_b;
    assign r_mag  = mag_a % div_b;
    assign quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem    = neg_a ? -r_mag : r_mag;

    // Next-state and counter control for the busy period.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    cnt_nx   = op_div ? DC : MC;
                end
            end
            RUN: begin
                if (cnt == 4'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                    commit   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Capture the result at accept time; commit it at end of busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else if (start) begin
            pend_hi <= op_div ? rem  : prod[63:32];
            pend_lo <= op_div ? quot : prod[31:0];
            pend_we <= ~(op_div & b_zero);
        end
    end

    // HI/LO: committed results or direct moves when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            if (pend_we) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (!busy && !req) begin
            if (op_mthi) hi <= a;
            if (op_mtlo) lo <= a;
        end
    end

    assign xlu_out = !reset  ? 32'd0 :
                     op_mfhi ? hi    :
                     op_mflo ? lo    : 32'd0;

endmodule

// File: tb/tb_e_xlu.sv
// tb_e_xlu: directed checks for e_xlu.
// Vector table plus hand sequences for flush, reset and collisions.
module tb_e_xlu;

    localparam logic [3:0] MULT  = 4'b0000;
    localparam logic [3:0] MULTU = 4'b0001;
    localparam logic [3:0] DIV   = 4'b0010;
    localparam logic [3:0] DIVU  = 4'b0011;
    localparam logic [3:0] MTHI  = 4'b0100;
    localparam logic [3:0] MTLO  = 4'b0101;
    localparam logic [3:0] MFHI  = 4'b0110;
    localparam logic [3:0] MFLO  = 4'b0111;
    localparam logic [3:0] NONE  = 4'b1000;

    logic        clk;
    logic        reset;
    logic [3:0]  xlu_op;
    logic [31:0] a, b;
    logic        req;
    logic        start, busy;
    logic [31:0] hi, lo, xlu_out;

    int n_tests;
    int n_fail;

    e_xlu dut (
        .clk     (clk),
        .reset   (reset),
        .xlu_op  (xlu_op),
        .a       (a),
        .b       (b),
        .req     (req),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .xlu_out (xlu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int n);
        int cnt;
        xlu_op = op;
        a = va;
        b = vb;
        #1;
        check({name, " start"}, 32'(start), 32'd1);
        step();
        xlu_op = NONE;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            step();
        end
        check({name, " busy cycles"}, 32'(cnt), 32'(n));
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
    endtask

    initial begin
        bit seen30;
        n_tests = 0;
        n_fail  = 0;
        reset  = 1'b0;
        xlu_op = MULT;
        a      = 32'd5;
        b      = 32'd6;
        req    = 1'b0;

        vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
        vecs[4] = '{DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 10};
        vecs[5] = '{DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10};
        vecs[6] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5};
        vecs[7] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5};

        #1;
        check("start in reset", 32'(start), 32'd0);
        xlu_op = MFHI;
        #1;
        check("xlu_out in reset", xlu_out, 32'd0);
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset  = 1'b1;
        xlu_op = NONE;
        step();

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].n);
            xlu_op = MFHI;
            #1;
            check($sformatf("vec%0d mfhi", i), xlu_out, vecs[i].hi);
            xlu_op = MFLO;
            #1;
            check($sformatf("vec%0d mflo", i), xlu_out, vecs[i].lo);
            xlu_op = NONE;
            step();
        end

        xlu_op = MTHI; a = 32'h11;
        step();
        xlu_op = MTLO; a = 32'h22;
        step();
        check("mthi idle 0x11", hi, 32'h11);
        check("mtlo idle 0x22", lo, 32'h22);
        do_op("divu by zero", DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10);

        xlu_op = MULT; a = 32'd5; b = 32'd6; req = 1'b1;
        #1;
        check("flush start", 32'(start), 32'd0);
        step();
        req = 1'b0; xlu_op = NONE;
        check("flush busy", 32'(busy), 32'd0);
        step();
        check("flush busy later", 32'(busy), 32'd0);
        check("flush hi", hi, 32'h11);
        check("flush lo", lo, 32'h22);

        xlu_op = MULT; a = 32'd5; b = 32'd6;
        step();
        xlu_op = MTHI; a = 32'h1234;
        step();
        check("mthi while busy hi", hi, 32'h11);
        xlu_op = NONE;
        while (busy) step();
        check("mult 5*6 hi", hi, 32'd0);
        check("mult 5*6 lo", lo, 32'd30);

        xlu_op = MTHI; a = 32'h1234;
        step();
        xlu_op = NONE;
        check("mthi idle 0x1234", hi, 32'h1234);

        xlu_op = MTLO; a = 32'h77;
        step();
        xlu_op = MULT; a = 32'd5; b = 32'd6;
        #1;
        check("mid-reset start", 32'(start), 32'd1);
        step();
        xlu_op = NONE;
        step();
        check("mid-reset busy cyc2", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset hi", hi, 32'd0);
        check("mid-reset lo", lo, 32'd0);
        reset = 1'b1;
        seen30 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (lo == 32'd30) seen30 = 1'b1;
            step();
        end
        check("mid-reset no 30", 32'(seen30), 32'd0);

        xlu_op = MULTU; a = 32'd2; b = 32'd3;
        #1;
        check("b2b start T", 32'(start), 32'd1);
        step();
        xlu_op = NONE;
        step();
        step();
        xlu_op = DIV; a = 32'd9; b = 32'd3;
        #1;
        check("collision start", 32'(start), 32'd0);
        step();
        xlu_op = NONE;
        step();
        step();
        check("b2b busy T+6", 32'(busy), 32'd0);
        check("b2b lo T+6", lo, 32'd6);
        check("b2b hi T+6", hi, 32'd0);
        do_op("reissue div", DIV, 32'd9, 32'd3, 32'd0, 32'd3, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/e_xlu.md
# e_xlu

Multiply/divide unit for the E stage of the five-stage MIPS32 pipeline. Consumes the 4-bit `xlu_op` code and the forwarded rs/rt operands issued by the E-stage controller. Owns the HI/LO registers and runs fixed-latency mult/multu/div/divu operations. Exports `start`/`busy` so the hazard unit can stall D-stage mult/div/mthi/mtlo/mfhi/mflo instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `xlu_op`  in  4  E-stage op code: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo, 1000 none. Codes 1001-1111 are treated as none.
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `req`  in  1  exception/interrupt flush of the current E-stage instruction.
- `start`  out  1  combinational; an operation is accepted this cycle.
- `busy`  out  1  registered; an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `xlu_out`  out  32  HI when `xlu_op`=0110, LO when 0111, else 0.

## Operation
- The unit is idle when `busy`=0.
- Accept: `start` = (`xlu_op` is 0000-0011) & !`busy` & !`req` & `reset`.
  - On accept, the result is computed from `a` and `b` as sampled in the start cycle.
  - The result is held in internal pending registers.
  - A down-counter is loaded with MULT_CYCLES or DIV_CYCLES.
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; the counter decrements every cycle.
  - RUN → IDLE when the counter reaches 1. On that edge, HI/LO take the pending values and `busy` clears.
- Arithmetic:
  - mult: {HI,LO} = signed(a) × signed(b), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): the full DIV_CYCLES busy period still runs, but HI/LO keep their prior values.
- mthi/mtlo:
  - When !`busy` & !`req`, HI (or LO) ← `a` at the clock edge.
  - When `busy`=1 or `req`=1, the write is ignored.
- mfhi/mflo: purely combinational reads through `xlu_out`. Reads do not change state.
- A mult/div op presented while `busy`=1 is ignored: no restart, no `start`, and the in-flight result is unaffected. The hazard unit guarantees this case does not occur in the legal flow.
- `req`=1 cancels only the E-stage op in that same cycle. An operation already in RUN continues and commits HI/LO normally.
- `reset`=0 at any clock edge, including mid-operation:
  - HI, LO, counter, pending registers ← 0; `busy` ← 0.
  - Any in-flight result is discarded.
  - `start` is 0 while `reset`=0.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0. `start`=0 and `xlu_out`=0 while in reset.
- Start in cycle T:
  - `start`=1 in T only.
  - `busy`=1 in cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible from cycle T+N+1, together with `busy`=0.
- Back-to-back: a new op may start in cycle T+N+1.
- mthi/mtlo in cycle T: the new value is visible on `hi`/`lo` in T+1.
- Stall contract for the hazard unit: stall D-stage md-class instructions while `start` | `busy`.

## Test plan
- Signed mult:
  - Stimulus: reset, then mult with a=0xFFFFFFFE (-2), b=3.
  - Required: `start` for 1 cycle, then `busy` for 5 cycles. Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi gives `xlu_out`=0xFFFFFFFF.
- Unsigned mult:
  - Stimulus: multu with a=0xFFFFFFFE, b=3.
  - Required: after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA.
- Signed and unsigned divide:
  - Stimulus: div with a=0xFFFFFFF9 (-7), b=2.
  - Required: `busy` for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Stimulus: divu with a=7, b=0, starting from HI=0x11, LO=0x22.
  - Required: `busy` for 10 cycles; HI=0x11, LO=0x22 unchanged.
- Flush and ignore:
  - Stimulus: mult with `req`=1.
  - Required: `start`=0, `busy` stays 0, HI/LO unchanged.
  - Stimulus: mthi a=0x1234 while `busy`=1.
  - Required: the write is ignored.
  - Stimulus: mthi a=0x1234 while idle.
  - Required: HI=0x1234 the next cycle.
- Reset mid-op:
  - Stimulus: start mult a=5, b=6, then pull `reset` low in busy cycle 2.
  - Required: on the next edge `busy`=0 and HI=LO=0. No 30 ever appears on LO.
- Back-to-back and collision:
  - Stimulus: start multu a=2, b=3, then present div a=9, b=3 in busy cycle 3.
  - Required: div ignored; LO=6 at T+6. A div re-issued at T+6 is accepted and yields LO=3, HI=0 at T+17.
